// File: rtl/data_memory_pipe.sv
// data_memory_pipe: single-port word memory with byte enables and a read
// pipeline of RD_LAT (1 or 2) cycles.
// After reset the memory is initialised one word per cycle: address k gets
// k+1 for k < 7, every other address gets 0.
// Error pulses flag simultaneous read/write requests and out-of-range addresses.
// Optional feature: define DATA_MEMORY_PIPE_PARITY_EN to store one even-parity
// bit per word and check it on every read.
module data_memory_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic [ADDR_W-1:0]   endereco,
    input  logic [DATA_W-1:0]   escreveDado,
    input  logic [DATA_W/8-1:0] byteEn,
    input  logic                injetaParidade,
    output logic [DATA_W-1:0]   leDado,
    output logic                leValido,
    output logic                ocupado,
    output logic                erroRW,
    output logic                erroEnd,
    output logic                erroParidade
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  merged;
    logic [DATA_W-1:0]  init_val;
    logic               is_ready;
    logic               acc_wr;
    logic               acc_rd;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    logic               lk_valid;
    logic [DATA_W-1:0]  lk_data;
    logic               lk_perr;

    logic               src_valid;
    logic [DATA_W-1:0]  src_data;
    logic               src_perr;

    logic [DATA_W-1:0]  le_dado_q, le_dado_d;
    logic               le_valido_q, le_valido_d;
    logic               erro_rw_q, erro_rw_d;
    logic               erro_end_q, erro_end_d;
    logic               erro_par_q, erro_par_d;

    // Request decode; the memory is read combinationally so a write merge and a
    // read lookup both see the word as it stands after the previous edge.
    always_comb begin
        in_range = ({1'b0, endereco} < DEPTH_L);
        idx      = endereco[IDX_W-1:0];
        rd_word  = mem[idx];
        is_ready = (state_q == READY);
        acc_wr   = is_ready & memWrite & in_range;
        acc_rd   = is_ready & memRead & ~memWrite;
        init_val = (int'(cnt_q) < 7) ? DATA_W'(int'(cnt_q) + 1) : '0;
    end

    // Byte-enable merge: disabled lanes keep the currently stored byte.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_merge
            assign merged[8*gi +: 8] = byteEn[gi] ? escreveDado[8*gi +: 8]
                                                  : rd_word[8*gi +: 8];
        end
    endgenerate

    // Write-port select: the init sweep owns the port while in INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = merged;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = init_val;
        end else if (acc_wr) begin
            mem_we    = 1'b1;
        end
    end

    // Word storage; contents are not reset, the init sweep rewrites them.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef DATA_MEMORY_PIPE_PARITY_EN
    logic par_mem [DEPTH];
    logic par_wbit;

    // Even parity over the word actually written; injection flips it.
    always_comb begin
        par_wbit = ^mem_wdata;
        if (state_q == READY) begin
            par_wbit = (^mem_wdata) ^ injetaParidade;
        end
    end

    // Parity bit storage alongside each word.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            par_mem[mem_waddr] <= par_wbit;
        end
    end

    // Read lookup with parity check.
    always_comb begin
        lk_valid = acc_rd;
        lk_data  = in_range ? rd_word : '0;
        lk_perr  = acc_rd & in_range & ((^rd_word) ^ par_mem[idx]);
    end
`else
    logic unused_inj;
    assign unused_inj = injetaParidade;

    // Read lookup; without parity storage there is never a parity error.
    always_comb begin
        lk_valid = acc_rd;
        lk_data  = in_range ? rd_word : '0;
        lk_perr  = 1'b0;
    end
`endif

    // Optional extra read stage so the result appears RD_LAT edges after the request.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid_q, s1_valid_d;
            logic [DATA_W-1:0] s1_data_q, s1_data_d;
            logic              s1_perr_q, s1_perr_d;

            // Stage-1 next values are the raw lookup.
            always_comb begin
                s1_valid_d = lk_valid;
                s1_data_d  = lk_data;
                s1_perr_d  = lk_perr;
            end

            // Stage-1 registers, cleared by reset so in-flight reads are dropped.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_perr_q  <= 1'b0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                    s1_perr_q  <= s1_perr_d;
                end
            end

            assign src_valid = s1_valid_q;
            assign src_data  = s1_data_q;
            assign src_perr  = s1_perr_q;
        end else begin : g_lat1
            assign src_valid = lk_valid;
            assign src_data  = lk_data;
            assign src_perr  = lk_perr;
        end
    endgenerate

    // Next state for the init FSM, outputs and error pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == LAST_IDX) begin
                state_d = READY;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
        le_valido_d = src_valid;
        le_dado_d   = src_valid ? src_data : le_dado_q;
        erro_par_d  = src_valid & src_perr;
        erro_rw_d   = is_ready & memRead & memWrite;
        erro_end_d  = is_ready & (memRead | memWrite) & ~in_range;
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            le_dado_q   <= '0;
            le_valido_q <= 1'b0;
            erro_rw_q   <= 1'b0;
            erro_end_q  <= 1'b0;
            erro_par_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            le_dado_q   <= le_dado_d;
            le_valido_q <= le_valido_d;
            erro_rw_q   <= erro_rw_d;
            erro_end_q  <= erro_end_d;
            erro_par_q  <= erro_par_d;
        end
    end

    assign ocupado      = (state_q == INIT);
    assign leDado       = le_dado_q;
    assign leValido     = le_valido_q;
    assign erroRW       = erro_rw_q;
    assign erroEnd      = erro_end_q;
    assign erroParidade = erro_par_q;

endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 256: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have port clock, input, width 1: single clock; all logic on posedge.
REQ-006 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port memRead, input, width 1: read request, sampled each cycle.
REQ-008 SHALL have port memWrite, input, width 1: write request, sampled each cycle.
REQ-009 SHALL have port endereco, input, width ADDR_W: word address.
REQ-010 SHALL have port escreveDado, input, width DATA_W: write data.
REQ-011 SHALL have port byteEn, input, width DATA_W/8: per-byte write enable; bit i covers bits [8i+7:8i].
REQ-012 SHALL have port injetaParidade, input, width 1: on an accepted write, store the inverted parity bit (test aid).
REQ-013 SHALL have port leDado, output, width DATA_W: read data.
REQ-014 SHALL have port leValido, output, width 1: one-cycle pulse qualifying leDado.
REQ-015 SHALL have port ocupado, output, width 1: high while initialisation runs; requests are ignored while high.
REQ-016 SHALL have port erroRW, output, width 1: one-cycle pulse on a simultaneous read and write request.
REQ-017 SHALL have port erroEnd, output, width 1: one-cycle pulse on a request with endereco >= DEPTH.
REQ-018 SHALL have port erroParidade, output, width 1: pulse coincident with leValido on a parity mismatch.

Function
REQ-019 SHALL implement a state machine with states INIT and READY; reset enters INIT with init counter = 0.
REQ-020 INIT SHALL write one word per cycle at counter address: value k+1 at addresses k = 0..6 (if k < DEPTH), 0 elsewhere, with correct parity.
REQ-021 The machine SHALL go INIT -> READY after writing address DEPTH-1; ocupado = 1 for exactly DEPTH cycles after reset release.
REQ-022 In READY, an accepted write (memWrite=1, memRead=0, in range) SHALL update only the enabled bytes at the posedge.
REQ-023 In READY, an accepted read SHALL drive leDado/leValido exactly RD_LAT cycles after the request edge; back-to-back reads SHALL be fully pipelined, one result per cycle.
REQ-024 A read one cycle after a write to the same address SHALL return the new data (write-first).
REQ-025 memRead=1 and memWrite=1 together SHALL perform the write, drop the read (no leValido), and pulse erroRW.
REQ-026 An out-of-range write SHALL be dropped; an out-of-range read SHALL return leDado = 0 with leValido; both SHALL pulse erroEnd.
REQ-027 leDado SHALL hold its last value when leValido = 0.
REQ-028 Requests while ocupado = 1 SHALL be ignored with no error pulses.

Reset
REQ-029 reset_n low SHALL asynchronously clear leDado, leValido, erroRW, erroEnd, erroParidade and the read pipeline, set ocupado = 1, and set state INIT with counter = 0.
REQ-030 Reset mid-INIT or mid-read SHALL discard in-flight results; initialisation SHALL restart from address 0 after release.

Configuration
REQ-031 With macro DATA_MEMORY_PIPE_PARITY_EN defined, each word SHALL store an even-parity bit computed over the merged post-byte-enable word, and reads SHALL check it.
REQ-032 Without DATA_MEMORY_PIPE_PARITY_EN, no parity storage SHALL exist, injetaParidade SHALL be ignored, and erroParidade SHALL be tied to 0.

Verification
REQ-033 Release reset with defaults -> ocupado high for 256 cycles; then read address 3 -> leDado = 0x04, with leValido one cycle later.
REQ-034 Write 0xA5 to address 10, then read address 10 on the next cycle -> leDado = 0xA5 with leValido at RD_LAT.
REQ-035 Assert memRead and memWrite together at address 20 with data 0x3C -> erroRW pulses and there is no leValido; a later read of address 20 returns 0x3C.
REQ-036 With DATA_W=16, write 0x1234 with byteEn=11, then 0xABCD with byteEn=01 -> a read returns 0x12CD.
REQ-037 Assert reset_n low at init counter 100, then release -> outputs are 0 and ocupado stays high for a full DEPTH more cycles.
REQ-038 With parity enabled, write 0x55 with injetaParidade=1, then read -> erroParidade = 1 together with leValido and leDado = 0x55.
